// File: rtl/button_ctrl.sv
// Five-button debounce and event controller with a four-word register window:
// STATE, PRESS (W1C), RELEASE (W1C) and IE, plus a level interrupt.
module button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  button_input,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0] s1_reg;
  logic [4:0] s2_reg;
  logic [4:0] stable;
  logic [4:0] hit;
  logic [4:0] press_set;
  logic [4:0] release_set;
  logic [4:0] press_reg;
  logic [4:0] release_reg;
  logic [4:0] ie_reg;
  logic [4:0] press_clr;
  logic [4:0] release_clr;
  logic [4:0] rd_mux;
  logic [1:0] sel;
  logic       unused_bits;

  assign sel         = addr[3:2];
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:5]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= button_input;
      s2_reg <= s1_reg;
    end
  end

  // Each button owns its counter; it only runs while s2 disagrees with stable.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_deb
      logic [CNT_W-1:0] cnt_reg;
      logic             stable_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else if (s2_reg[gi] == stable_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_MAX) begin
          stable_reg <= s2_reg[gi];
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign stable[gi] = stable_reg;
      assign hit[gi]    = (cnt_reg == CNT_MAX);
    end
  endgenerate

  assign press_set   =  s2_reg & ~stable & hit;
  assign release_set = ~s2_reg &  stable & hit;
  assign press_clr   = (wr_en && sel == 2'd1) ? wdata[4:0] : 5'd0;
  assign release_clr = (wr_en && sel == 2'd2) ? wdata[4:0] : 5'd0;

  always_comb begin
    rd_mux = 5'd0;
    case (sel)
      2'd0: rd_mux = stable;
      2'd1: rd_mux = press_reg;
      2'd2: rd_mux = release_reg;
      2'd3: rd_mux = ie_reg;
      default: rd_mux = 5'd0;
    endcase
  end

  // Set is OR-ed after the clear so a same-cycle event survives a W1C write.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_reg   <= '0;
      release_reg <= '0;
      ie_reg      <= '0;
      rdata       <= '0;
    end else begin
      press_reg   <= (press_reg & ~press_clr) | press_set;
      release_reg <= (release_reg & ~release_clr) | release_set;
      if (wr_en && sel == 2'd3) ie_reg <= wdata[4:0];
      rdata <= {27'd0, rd_mux};
    end
  end

  assign irq = |(press_reg & ie_reg);

endmodule

// File: tb/tb_button_ctrl.sv
// Scoreboard bench for button_ctrl with a 4-cycle debounce window.
module tb_button_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  button_input;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  button_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .button_input(button_input),
    .addr(addr),
    .wr_en(wr_en),
    .wdata(wdata),
    .rdata(rdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    addr  = {28'd0, a, 2'b00};
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wdata = '0;
  endtask

  // Expected value is queued when the address is driven, compared once rdata is produced.
  task automatic read_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] e;
    string       t;
    addr = {28'd0, a, 2'b00};
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_val(t, rdata, e);
  endtask

  initial begin
    rst          = 1'b1;
    button_input = 5'h1F;
    addr         = '0;
    wr_en        = 1'b0;
    wdata        = '0;

    // Reset with all buttons held; STATE accepts 5 edges after s1 capture.
    tick();
    tick();
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) read_reg("rst_state_low", 2'd0, 32'h0);
    read_reg("rst_state_high", 2'd0, 32'h1F);
    read_reg("rst_press", 2'd1, 32'h1F);
    check_val("rst_irq_ie0", {31'd0, irq}, 32'd0);
    write_reg(2'd1, 32'h1F);
    button_input = 5'h00;
    repeat (8) tick();
    read_reg("all_release", 2'd2, 32'h1F);
    write_reg(2'd2, 32'h1F);
    read_reg("press_clear", 2'd1, 32'h0);
    read_reg("release_clear", 2'd2, 32'h0);

    // Bounce on bit 0: never holds for a full window.
    write_reg(2'd3, 32'h1F);
    for (int r = 0; r < 5; r++) begin
      button_input = 5'h01;
      for (int k = 0; k < 3; k++) begin
        read_reg("bounce_state", 2'd0, 32'h0);
        check_val("bounce_irq", {31'd0, irq}, 32'd0);
      end
      button_input = 5'h00;
      read_reg("bounce_state", 2'd0, 32'h0);
      check_val("bounce_irq", {31'd0, irq}, 32'd0);
    end
    repeat (6) tick();
    read_reg("bounce_press", 2'd1, 32'h0);
    check_val("bounce_irq_end", {31'd0, irq}, 32'd0);

    // Press on bit 2 with only bit 2 enabled.
    write_reg(2'd3, 32'h04);
    read_reg("ie_read", 2'd3, 32'h04);
    button_input = 5'h04;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("press_irq_pre", {31'd0, irq}, 32'd0);
    end
    tick();
    check_val("press_irq_rise", {31'd0, irq}, 32'd1);
    read_reg("press_bit2", 2'd1, 32'h04);
    write_reg(2'd1, 32'h04);
    check_val("press_irq_drop", {31'd0, irq}, 32'd0);
    read_reg("press_cleared", 2'd1, 32'h0);

    // Bit 1 press accepted on the same edge as a W1C write of bit 1.
    button_input = 5'h06;
    repeat (5) tick();
    write_reg(2'd1, 32'h02);
    read_reg("collide_press", 2'd1, 32'h02);
    check_val("collide_irq", {31'd0, irq}, 32'd0);

    // Bit 3 press, then release with every interrupt enabled.
    button_input = 5'h0E;
    repeat (8) tick();
    read_reg("b3_press", 2'd1, 32'h0A);
    write_reg(2'd1, 32'h1F);
    write_reg(2'd3, 32'h1F);
    write_reg(2'd0, 32'h1F);
    read_reg("state_wr_ignored", 2'd0, 32'h0E);
    button_input = 5'h06;
    repeat (8) tick();
    read_reg("rel_release", 2'd2, 32'h08);
    read_reg("rel_press", 2'd1, 32'h0);
    check_val("rel_irq", {31'd0, irq}, 32'd0);
    read_reg("rel_state", 2'd0, 32'h06);

    // Reset two cycles after bit 4 rises: count restarts from scratch.
    button_input = 5'h16;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_rdata", rdata, 32'd0);
    for (int k = 0; k < 6; k++) read_reg("mid_state_low", 2'd0, 32'h0);
    read_reg("mid_state_high", 2'd0, 32'h16);
    read_reg("mid_press", 2'd1, 32'h16);
    read_reg("mid_ie", 2'd3, 32'h0);
    check_val("mid_irq", {31'd0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
